// File: rtl/enemy_wave_ctrl.sv
// enemy_wave_ctrl: four-lane enemy scheduler with LFSR spawning, attack hit window,
// escape damage, score/lives bookkeeping and an IDLE/RUN/OVER game FSM.
module enemy_wave_ctrl #(
    parameter int POS_MAX = 31,
    parameter int HIT_LO = 12,
    parameter int HIT_HI = 20,
    parameter int SPAWN_GAP = 8,
    parameter int LIVES_INIT = 3,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       start,
    input  logic       attack,
    input  logic [1:0] attack_lane,
    output logic [4:0] pos_0,
    output logic [4:0] pos_1,
    output logic [4:0] pos_2,
    output logic [4:0] pos_3,
    output logic [3:0] alive,
    output logic [3:0] hit,
    output logic       damage,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [1:0] state
);
    localparam int CW = (SPAWN_GAP > 2) ? $clog2(SPAWN_GAP) : 1;
    localparam logic [CW-1:0] CMAX = CW'(SPAWN_GAP - 1);
    localparam logic [4:0] PMAX = 5'(POS_MAX);
    localparam logic [4:0] PLO = 5'(HIT_LO);
    localparam logic [4:0] PHI = 5'(HIT_HI);
    localparam logic [1:0] LINIT = 2'(LIVES_INIT);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} st_t;

    st_t st_q, st_n;
    logic [4:0] pos_q [4];
    logic [4:0] pos_n [4];
    logic [3:0] alive_q, alive_n, hit_q, hit_n, esc;
    logic damage_q, damage_n, kill;
    logic [7:0] score_q, score_n, lfsr_q, lfsr_n, lfsr_adv;
    logic [1:0] lives_q, lives_n;
    logic [2:0] n_esc;
    logic [CW-1:0] cnt_q, cnt_n;

    assign lfsr_adv = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign kill = attack && alive_q[attack_lane] && pos_q[attack_lane] >= PLO && pos_q[attack_lane] <= PHI;
    assign n_esc = 3'($countones(esc));

    always_comb begin
        st_n = st_q;
        pos_n = pos_q;
        alive_n = alive_q;
        hit_n = '0;
        damage_n = 1'b0;
        score_n = score_q;
        lives_n = lives_q;
        cnt_n = cnt_q;
        lfsr_n = lfsr_q;
        esc = '0;
        case (st_q)
            IDLE: if (start) begin
                st_n = RUN;
                pos_n = '{default: '0};
                alive_n = '0;
                score_n = '0;
                lives_n = LINIT;
                cnt_n = '0;
            end
            RUN: begin
                if (kill) begin
                    alive_n[attack_lane] = 1'b0;
                    pos_n[attack_lane] = '0;
                    hit_n[attack_lane] = 1'b1;
                    score_n = score_q + 8'(score_q != 8'hFF);
                end
                if (step) begin
                    // a lane killed on this edge neither advances nor escapes
                    for (int i = 0; i < 4; i++)
                        if (alive_q[i] && !(kill && attack_lane == 2'(i))) begin
                            esc[i] = pos_q[i] == PMAX;
                            alive_n[i] = !esc[i];
                            pos_n[i] = esc[i] ? 5'd0 : pos_q[i] + 5'd1;
                        end
                    lives_n = ({1'b0, lives_q} <= n_esc) ? 2'd0 : lives_q - n_esc[1:0];
                    damage_n = |esc;
                    cnt_n = (cnt_q == CMAX) ? '0 : cnt_q + CW'(1);
                    if (cnt_q == CMAX) begin
                        lfsr_n = lfsr_adv;
                        if (!alive_q[lfsr_adv[1:0]] && lives_n != 2'd0) begin
                            alive_n[lfsr_adv[1:0]] = 1'b1;
                            pos_n[lfsr_adv[1:0]] = '0;
                        end
                    end
                    if (|esc && lives_n == 2'd0) st_n = OVER;
                end
            end
            OVER: if (start) st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= IDLE;
            pos_q <= '{default: '0};
            alive_q <= '0;
            hit_q <= '0;
            damage_q <= 1'b0;
            score_q <= '0;
            lives_q <= LINIT;
            cnt_q <= '0;
            lfsr_q <= LFSR_SEED;
        end else begin
            st_q <= st_n;
            pos_q <= pos_n;
            alive_q <= alive_n;
            hit_q <= hit_n;
            damage_q <= damage_n;
            score_q <= score_n;
            lives_q <= lives_n;
            cnt_q <= cnt_n;
            lfsr_q <= lfsr_n;
        end
    end

    assign pos_0 = pos_q[0];
    assign pos_1 = pos_q[1];
    assign pos_2 = pos_q[2];
    assign pos_3 = pos_q[3];
    assign alive = alive_q;
    assign hit = hit_q;
    assign damage = damage_q;
    assign score = score_q;
    assign lives = lives_q;
    assign state = st_q;
endmodule

// File: tb/tb_enemy_wave_ctrl.sv
// tb_enemy_wave_ctrl: directed game scenario with hand-computed lane, score,
// lives, LFSR and FSM expectations.
module tb_enemy_wave_ctrl;
    logic clk = 1'b0, rst = 1'b1, step = 1'b0, start = 1'b0, attack = 1'b0;
    logic [1:0] attack_lane = '0;
    logic [4:0] pos_0, pos_1, pos_2, pos_3;
    logic [3:0] alive, hit;
    logic damage;
    logic [7:0] score;
    logic [1:0] lives, state;
    int total = 0, bad = 0;

    enemy_wave_ctrl dut (
        .clk(clk), .rst(rst), .step(step), .start(start), .attack(attack),
        .attack_lane(attack_lane), .pos_0(pos_0), .pos_1(pos_1), .pos_2(pos_2),
        .pos_3(pos_3), .alive(alive), .hit(hit), .damage(damage), .score(score),
        .lives(lives), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic a, input logic [1:0] l, input logic st);
        step = s;
        attack = a;
        attack_lane = l;
        start = st;
        @(posedge clk);
        #1;
        step = 1'b0;
        attack = 1'b0;
        start = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_state"}, 32'(state), 0);
        chk({p, "_pos"}, {12'd0, pos_3, pos_2, pos_1, pos_0}, 0);
        chk({p, "_alive"}, 32'(alive), 0);
        chk({p, "_hit"}, 32'(hit), 0);
        chk({p, "_damage"}, 32'(damage), 0);
        chk({p, "_score"}, 32'(score), 0);
        chk({p, "_lives"}, 32'(lives), 3);
        chk({p, "_lfsr"}, 32'(dut.lfsr_q), 32'hA5);
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset("rst");
        steps(1);
        chk("idle_step_alive", 32'(alive), 0);
        chk("idle_step_pos0", 32'(pos_0), 0);
        cyc(1'b0, 1'b0, 2'd0, 1'b1);
        chk("start_run", 32'(state), 1);
        steps(8);
        chk("s8_alive", 32'(alive), 32'h4);
        chk("s8_pos2", 32'(pos_2), 0);
        chk("s8_lfsr", 32'(dut.lfsr_q), 32'h4A);
        chk("s8_damage", 32'(damage), 0);
        chk("s8_lives", 32'(lives), 3);
        steps(12);
        chk("s20_pos2", 32'(pos_2), 12);
        chk("s20_pos1", 32'(pos_1), 4);
        chk("s20_alive", 32'(alive), 32'h6);
        cyc(1'b0, 1'b1, 2'd2, 1'b0);
        chk("kill12_hit", 32'(hit), 32'h4);
        chk("kill12_alive", 32'(alive), 32'h2);
        chk("kill12_pos2", 32'(pos_2), 0);
        chk("kill12_score", 32'(score), 1);
        cyc(1'b0, 1'b0, 2'd0, 1'b0);
        chk("hit_one_cycle", 32'(hit), 0);
        cyc(1'b0, 1'b1, 2'd3, 1'b0);
        chk("empty_hit", 32'(hit), 0);
        chk("empty_alive", 32'(alive), 32'h2);
        chk("empty_score", 32'(score), 1);
        steps(7);
        chk("s27_pos1", 32'(pos_1), 11);
        chk("s27_pos2", 32'(pos_2), 3);
        chk("s27_alive", 32'(alive), 32'h6);
        cyc(1'b0, 1'b1, 2'd1, 1'b0);
        chk("miss11_hit", 32'(hit), 0);
        chk("miss11_alive", 32'(alive), 32'h6);
        chk("miss11_score", 32'(score), 1);
        steps(10);
        chk("s37_pos1", 32'(pos_1), 21);
        chk("s37_pos2", 32'(pos_2), 13);
        chk("s37_pos0", 32'(pos_0), 5);
        cyc(1'b0, 1'b1, 2'd1, 1'b0);
        chk("miss21_hit", 32'(hit), 0);
        chk("miss21_alive", 32'(alive), 32'h7);
        chk("miss21_score", 32'(score), 1);
        steps(2);
        chk("s39_pos2", 32'(pos_2), 15);
        cyc(1'b1, 1'b1, 2'd2, 1'b0);
        chk("both_hit", 32'(hit), 32'h4);
        chk("both_pos2", 32'(pos_2), 0);
        chk("both_alive", 32'(alive), 32'h3);
        chk("both_pos1", 32'(pos_1), 24);
        chk("both_pos0", 32'(pos_0), 8);
        chk("both_score", 32'(score), 2);
        chk("both_lfsr", 32'(dut.lfsr_q), 32'hA9);
        steps(7);
        chk("s47_pos1", 32'(pos_1), 31);
        chk("s47_damage", 32'(damage), 0);
        steps(1);
        chk("esc1_damage", 32'(damage), 1);
        chk("esc1_lives", 32'(lives), 2);
        chk("esc1_alive", 32'(alive), 32'h9);
        chk("esc1_pos1", 32'(pos_1), 0);
        chk("esc1_pos0", 32'(pos_0), 16);
        cyc(1'b0, 1'b0, 2'd0, 1'b0);
        chk("damage_one_cycle", 32'(damage), 0);
        steps(15);
        chk("s63_pos0", 32'(pos_0), 31);
        chk("s63_alive", 32'(alive), 32'h9);
        chk("s63_lfsr", 32'(dut.lfsr_q), 32'hA7);
        steps(1);
        chk("esc2_lives", 32'(lives), 1);
        chk("esc2_damage", 32'(damage), 1);
        chk("esc2_alive", 32'(alive), 32'hC);
        chk("esc2_state", 32'(state), 1);
        steps(15);
        chk("s79_pos3", 32'(pos_3), 31);
        chk("s79_alive", 32'(alive), 32'hE);
        steps(1);
        chk("over_state", 32'(state), 2);
        chk("over_lives", 32'(lives), 0);
        chk("over_damage", 32'(damage), 1);
        chk("over_alive", 32'(alive), 32'h6);
        chk("over_pos2", 32'(pos_2), 16);
        cyc(1'b1, 1'b1, 2'd2, 1'b0);
        chk("over_ign_alive", 32'(alive), 32'h6);
        chk("over_ign_pos2", 32'(pos_2), 16);
        chk("over_ign_hit", 32'(hit), 0);
        chk("over_ign_score", 32'(score), 2);
        chk("over_ign_state", 32'(state), 2);
        cyc(1'b0, 1'b0, 2'd0, 1'b1);
        chk("over_to_idle", 32'(state), 0);
        chk("idle_hold_alive", 32'(alive), 32'h6);
        cyc(1'b0, 1'b0, 2'd0, 1'b1);
        chk("restart_state", 32'(state), 1);
        chk("restart_score", 32'(score), 0);
        chk("restart_lives", 32'(lives), 3);
        chk("restart_alive", 32'(alive), 0);
        steps(24);
        chk("g2_alive", 32'(alive), 32'hE);
        chk("g2_pos3", 32'(pos_3), 16);
        chk("g2_pos2", 32'(pos_2), 8);
        chk("g2_lfsr", 32'(dut.lfsr_q), 32'hDD);
        cyc(1'b0, 1'b0, 2'd0, 1'b1);
        chk("run_start_state", 32'(state), 1);
        chk("run_start_alive", 32'(alive), 32'hE);
        chk("run_start_pos3", 32'(pos_3), 16);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 2'd3, 1'b0);
        rst = 1'b0;
        chk_reset("midrst");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
